clint_timer: RTL and testbench

- Parametrised AXI4-Lite core-local interruptor: 64-bit free-running mtime, per-hart mtimecmp and msip, and timer/software interrupt outputs.
- Successor to the read-only mtime slave: mtime becomes writable, has a configurable tick prescaler, and gains compare-based interrupts for up to 4 harts.
- Sits on the CPU-side AXI4-Lite crossbar as a slave; mtip/msip route to each hart's CSR/trap logic.

---
 rtl/axi_lite_if.sv | 35 +++
 rtl/clint_timer.sv | 235 +++++++++++++++++++++++
 tb/tb_clint_timer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite bundle, 32-bit address/data with byte strobes.
// Modports: master drives requests, slave drives ready/response.
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/clint_timer.sv
// clint_timer: AXI4-Lite CLINT with prescaled 64-bit mtime, per-hart
// mtimecmp/msip. Ports: clk, reset, s (slave), mtip/msip per hart.
module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NUM_HARTS = 1,
  parameter int          TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_lite_if.slave            s,
  output logic [NUM_HARTS-1:0] mtip,
  output logic [NUM_HARTS-1:0] msip
);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {K_MSIP, K_CMP, K_TIME, K_NONE} kind_e;

  typedef struct packed {
    logic       ok;
    kind_e      kind;
    logic [1:0] hart;
    logic       hi;
  } dec_t;

  function automatic dec_t decode(input logic [31:2] a);
    dec_t d;
    d.ok   = 1'b0;
    d.kind = K_NONE;
    d.hart = a[3:2];
    d.hi   = a[2];
    if (a[31:16] == BASE_ADDR[31:16]) begin
      unique case (1'b1)
        a[15:14] == 2'b00: begin
          d.kind = K_MSIP;
          d.ok   = a[13:2] < 12'(NUM_HARTS);
        end
        a[15:14] == 2'b01: begin
          d.kind = K_CMP;
          d.hart = a[4:3];
          d.ok   = a[13:3] < 11'(NUM_HARTS);
        end
        a[15:3] == 13'h17FF: begin
          d.kind = K_TIME;
          d.ok   = 1'b1;
        end
        default: ;
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  st
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = st[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  logic [63:0]          mtime;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q;
  logic [31:0]          presc;
  logic                 tick;

  assign tick = (presc == 32'(TICK_DIV - 1));
  assign msip = msip_q;

  // read channel
  typedef enum logic {R_IDLE, R_RESP} rstate_e;
  rstate_e     rstate;
  logic        ar_rdy;
  logic        r_vld;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  dec_t        rdec;
  logic [31:0] rd_val;

  assign s.arready = ar_rdy;
  assign s.rvalid  = r_vld;
  assign s.rdata   = r_data;
  assign s.rresp   = r_resp;

  always_comb begin
    rdec   = decode(s.araddr[31:2]);
    rd_val = '0;
    unique case (rdec.kind)
      K_MSIP:
        for (int h = 0; h < NUM_HARTS; h++)
          if (rdec.hart == 2'(h)) rd_val = {31'd0, msip_q[h]};
      K_CMP:
        for (int h = 0; h < NUM_HARTS; h++)
          if (rdec.hart == 2'(h))
            rd_val = rdec.hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
      K_TIME:
        rd_val = rdec.hi ? mtime[63:32] : mtime[31:0];
      default: ;
    endcase
    if (!rdec.ok) rd_val = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rstate <= R_IDLE;
      ar_rdy <= 1'b1;
      r_vld  <= 1'b0;
      r_data <= '0;
      r_resp <= OKAY;
    end else begin
      unique case (rstate)
        R_IDLE:
          if (s.arvalid) begin
            rstate <= R_RESP;
            ar_rdy <= 1'b0;
            r_vld  <= 1'b1;
            r_data <= rd_val;
            r_resp <= rdec.ok ? OKAY : SLVERR;
          end
        R_RESP:
          if (s.rready) begin
            rstate <= R_IDLE;
            ar_rdy <= 1'b1;
            r_vld  <= 1'b0;
          end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // write channel
  typedef enum logic [2:0] {
    W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP
  } wstate_e;
  wstate_e     wstate;
  wstate_e     wnext;
  logic        aw_rdy;
  logic        w_rdy;
  logic        b_vld;
  logic [1:0]  b_resp;
  logic        aw_hs;
  logic        w_hs;
  logic        commit;
  logic [31:2] w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  dec_t        wdec;

  assign s.awready = aw_rdy;
  assign s.wready  = w_rdy;
  assign s.bvalid  = b_vld;
  assign s.bresp   = b_resp;

  assign aw_hs  = s.awvalid && aw_rdy;
  assign w_hs   = s.wvalid && w_rdy;
  assign commit = (wstate == W_COMMIT);
  assign wdec   = decode(w_addr);

  always_comb begin
    wnext = wstate;
    unique case (wstate)
      W_IDLE:
        if (aw_hs && w_hs) wnext = W_COMMIT;
        else if (aw_hs)    wnext = W_HAVE_A;
        else if (w_hs)     wnext = W_HAVE_D;
      W_HAVE_A: if (w_hs)      wnext = W_COMMIT;
      W_HAVE_D: if (aw_hs)     wnext = W_COMMIT;
      W_COMMIT:                wnext = W_RESP;
      W_RESP:   if (s.bready)  wnext = W_IDLE;
      default:                 wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate <= W_IDLE;
      aw_rdy <= 1'b1;
      w_rdy  <= 1'b1;
      b_vld  <= 1'b0;
      b_resp <= OKAY;
      w_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
    end else begin
      wstate <= wnext;
      aw_rdy <= (wnext == W_IDLE) || (wnext == W_HAVE_D);
      w_rdy  <= (wnext == W_IDLE) || (wnext == W_HAVE_A);
      b_vld  <= (wnext == W_RESP);
      if (aw_hs) w_addr <= s.awaddr[31:2];
      if (w_hs) begin
        w_data <= s.wdata;
        w_strb <= s.wstrb;
      end
      if (commit) b_resp <= wdec.ok ? OKAY : SLVERR;
    end
  end

  // timer, compare and software-interrupt registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime  <= '0;
      presc  <= '0;
      msip_q <= '0;
      mtip   <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      presc <= tick ? '0 : presc + 32'd1;
      // a software write to mtime wins over the tick in that cycle
      if (commit && wdec.ok && wdec.kind == K_TIME) begin
        if (wdec.hi) mtime[63:32] <= merge(mtime[63:32], w_data, w_strb);
        else         mtime[31:0]  <= merge(mtime[31:0], w_data, w_strb);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (commit && wdec.ok && wdec.hart == 2'(h)) begin
          if (wdec.kind == K_MSIP && w_strb[0]) msip_q[h] <= w_data[0];
          if (wdec.kind == K_CMP) begin
            if (wdec.hi)
              mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], w_data, w_strb);
            else
              mtimecmp[h][31:0] <= merge(mtimecmp[h][31:0], w_data, w_strb);
          end
        end
        mtip[h] <= (mtime >= mtimecmp[h]);
      end
    end
  end

  logic unused_lsb;
  assign unused_lsb = ^{s.araddr[1:0], s.awaddr[1:0]};
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: directed bench for two clint_timer instances
// (A: 2 harts, TICK_DIV=1; B: 1 hart, TICK_DIV=4) on a shared bus.
module tb_clint_timer;
  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;

  axi_lite_if ia ();
  axi_lite_if ib ();

  assign ia.awaddr  = awaddr;
  assign ia.awvalid = awvalid & ~sel;
  assign ia.wdata   = wdata;
  assign ia.wstrb   = wstrb;
  assign ia.wvalid  = wvalid & ~sel;
  assign ia.bready  = bready & ~sel;
  assign ia.araddr  = araddr;
  assign ia.arvalid = arvalid & ~sel;
  assign ia.rready  = rready & ~sel;

  assign ib.awaddr  = awaddr;
  assign ib.awvalid = awvalid & sel;
  assign ib.wdata   = wdata;
  assign ib.wstrb   = wstrb;
  assign ib.wvalid  = wvalid & sel;
  assign ib.bready  = bready & sel;
  assign ib.araddr  = araddr;
  assign ib.arvalid = arvalid & sel;
  assign ib.rready  = rready & sel;

  logic        awready_m, wready_m, bvalid_m, arready_m, rvalid_m;
  logic [1:0]  bresp_m, rresp_m;
  logic [31:0] rdata_m;

  assign awready_m = sel ? ib.awready : ia.awready;
  assign wready_m  = sel ? ib.wready  : ia.wready;
  assign bvalid_m  = sel ? ib.bvalid  : ia.bvalid;
  assign bresp_m   = sel ? ib.bresp   : ia.bresp;
  assign arready_m = sel ? ib.arready : ia.arready;
  assign rvalid_m  = sel ? ib.rvalid  : ia.rvalid;
  assign rresp_m   = sel ? ib.rresp   : ia.rresp;
  assign rdata_m   = sel ? ib.rdata   : ia.rdata;

  logic [1:0] mtip_a, msip_a;
  logic [0:0] mtip_b, msip_b;

  clint_timer #(
    .BASE_ADDR(32'h0200_0000), .NUM_HARTS(2), .TICK_DIV(1)
  ) dut_a (
    .clk(clk), .reset(reset_a), .s(ia.slave),
    .mtip(mtip_a), .msip(msip_a)
  );

  clint_timer #(
    .BASE_ADDR(32'h0200_0000), .NUM_HARTS(1), .TICK_DIV(4)
  ) dut_b (
    .clk(clk), .reset(reset_b), .s(ib.slave),
    .mtip(mtip_b), .msip(msip_b)
  );

  localparam logic [31:0] MSIP0 = 32'h0200_0000;
  localparam logic [31:0] MSIP1 = 32'h0200_0004;
  localparam logic [31:0] MSIP4 = 32'h0200_0010;
  localparam logic [31:0] CMP0L = 32'h0200_4000;
  localparam logic [31:0] CMP0H = 32'h0200_4004;
  localparam logic [31:0] CMP1L = 32'h0200_4008;
  localparam logic [31:0] CMP1H = 32'h0200_400C;
  localparam logic [31:0] TIMEL = 32'h0200_BFF8;
  localparam logic [31:0] TIMEH = 32'h0200_BFFC;
  localparam logic [31:0] HOLE  = 32'h0200_8000;

  int checks = 0;
  int failures = 0;
  logic m_first, m_next;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d,
                    output logic [1:0] r);
    int n;
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("r_latency", 64'(n), 64'd0);
    d = rdata_m;
    r = rresp_m;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  // mode 0: AW+W together, 1: W three cycles before AW, 2: AW before W
  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] st, input int mode, input int hold,
                    output logic [1:0] resp);
    int n;
    logic stable;
    awaddr = a;
    wdata  = d;
    wstrb  = st;
    bready = 1'b0;
    if (mode == 0) begin
      awvalid = 1'b1;
      wvalid  = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end else if (mode == 1) begin
      wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      chk("have_d_wready", 64'(wready_m), 64'd0);
      chk("have_d_awready", 64'(awready_m), 64'd1);
      repeat (2) @(negedge clk);
      awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
    end else begin
      awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      chk("have_a_awready", 64'(awready_m), 64'd0);
      chk("have_a_wready", 64'(wready_m), 64'd1);
      @(negedge clk);
      wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
    end
    n = 0;
    while (!bvalid_m && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_wait", 64'(n < 20), 64'd1);
    m_first = mtip_a[0];
    resp = bresp_m;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) m_next = mtip_a[0];
      if (!bvalid_m || bresp_m !== resp) stable = 1'b0;
    end
    if (hold > 0) chk("b_stable", 64'(stable), 64'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_single", 64'(bvalid_m), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(arready_m), 64'd1);
    chk("rst_awready", 64'(awready_m), 64'd1);
    chk("rst_wready", 64'(wready_m), 64'd1);
    chk("rst_rvalid", 64'(rvalid_m), 64'd0);
    chk("rst_bvalid", 64'(bvalid_m), 64'd0);
    chk("rst_rdata", 64'(rdata_m), 64'd0);
    chk("rst_mtip", 64'(mtip_a), 64'd0);
    chk("rst_msip", 64'(msip_a), 64'd0);

    // A: free-running mtime and reset compare values
    reset_a = 1'b0;
    repeat (10) @(negedge clk);
    rd(TIMEL, d, r);
    chk("mtime_10", 64'(d), 64'd10);
    chk("mtime_resp", 64'(r), 64'd0);
    chk("mtip_idle", 64'(mtip_a), 64'd0);
    rd(CMP0L, d, r);
    chk("cmp0_lo_rst", 64'(d), 64'hFFFF_FFFF);
    rd(CMP0H, d, r);
    chk("cmp0_hi_rst", 64'(d), 64'hFFFF_FFFF);

    // A: compare interrupt
    wr(TIMEL, 32'h0, 4'hF, 0, 0, r);
    chk("mtime_wr_resp", 64'(r), 64'd0);
    wr(CMP0H, 32'h0, 4'hF, 0, 0, r);
    wr(CMP0L, 32'h64, 4'hF, 0, 0, r);
    chk("mtip_before", 64'(mtip_a[0]), 64'd0);
    n = 0;
    while (!mtip_a[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("mtip_seen", 64'(n < 400), 64'd1);
    rd(TIMEL, d, r);
    chk("mtip_edge_time", 64'(d), 64'h65);
    chk("mtip_other", 64'(mtip_a[1]), 64'd0);
    wr(CMP0H, 32'hFFFF_FFFF, 4'hF, 0, 1, r);
    chk("mtip_at_commit", 64'(m_first), 64'd1);
    chk("mtip_cleared", 64'(m_next), 64'd0);

    // A: software interrupts
    wr(MSIP1, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    chk("msip_set", 64'(msip_a), 64'b10);
    rd(MSIP1, d, r);
    chk("msip_rb", 64'(d), 64'd1);
    wr(MSIP1, 32'h0, 4'hF, 0, 0, r);
    chk("msip_clr", 64'(msip_a), 64'b00);

    // A: handshake orderings
    wr(CMP1L, 32'h1234_5678, 4'hF, 1, 0, r);
    rd(CMP1L, d, r);
    chk("w_first_rb", 64'(d), 64'h1234_5678);
    wr(CMP1H, 32'hCAFE_F00D, 4'hF, 0, 5, r);
    chk("hold_bresp", 64'(r), 64'd0);
    rd(CMP1H, d, r);
    chk("hold_rb", 64'(d), 64'hCAFE_F00D);
    wr(MSIP0, 32'h1, 4'hF, 2, 0, r);
    chk("aw_first_msip", 64'(msip_a), 64'b01);
    wr(MSIP0, 32'h0, 4'hF, 0, 0, r);

    // A: unmapped accesses and byte strobes
    rd(MSIP4, d, r);
    chk("um_msip_rresp", 64'(r), 64'd2);
    chk("um_msip_rdata", 64'(d), 64'd0);
    rd(HOLE, d, r);
    chk("um_hole_rresp", 64'(r), 64'd2);
    chk("um_hole_rdata", 64'(d), 64'd0);
    wr(MSIP4, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    chk("um_msip_bresp", 64'(r), 64'd2);
    chk("um_msip_state", 64'(msip_a), 64'b00);
    wr(HOLE, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    chk("um_hole_bresp", 64'(r), 64'd2);
    wr(CMP0L, 32'hAABB_CCDD, 4'b0010, 0, 0, r);
    rd(CMP0L, d, r);
    chk("strb_lane1", 64'(d), 64'h0000_CC64);
    rd(CMP1L, d, r);
    chk("um_no_change", 64'(d), 64'h1234_5678);

    // B: prescaled mtime and 64-bit wrap
    sel = 1'b1;
    @(negedge clk);
    reset_b = 1'b0;
    repeat (40) @(negedge clk);
    rd(TIMEL, d, r);
    chk("div4_mtime", 64'(d), 64'd10);
    rd(MSIP1, d, r);
    chk("b_msip1_rresp", 64'(r), 64'd2);
    wr(TIMEH, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    wr(TIMEL, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    repeat (4) @(negedge clk);
    rd(TIMEL, d, r);
    chk("wrap_lo", 64'(d), 64'd0);
    rd(TIMEH, d, r);
    chk("wrap_hi", 64'(d), 64'd0);
    chk("b_mtip", 64'(mtip_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
